// File: rtl/ans_freq_table.sv
// ans_freq_table: programmable per-symbol frequency table feeding ans_encoder.
// Builds a cumulative-frequency table with a sequential prefix sum. It then
// maps raw symbols to (s_count, s_cumulative, total_count) tuples, using a
// valid/ready handshake on both sides.
//
// Ports:
//   clk, rst (sync, active-high), ena (clock enable)
//   cfg_we/cfg_sym/cfg_count : write one frequency entry
//   cfg_commit               : start cumulative-table build
//   tbl_rdy                  : table built, lookups accepted
//   err                      : sticky error (zero total, or zero-count symbol)
//   sym_in/sym_vld/sym_rdy   : symbol input handshake
//   s_count/s_cumulative/total_count/out_vld/out_rdy : tuple output handshake
//
// Optional feature macro: ANS_ZERO_SYM_CHECK_EN. When defined, a symbol
// whose count is zero is consumed without producing a tuple, and it sets err.
module ans_freq_table #(
  parameter int unsigned SYM_WIDTH   = 4,
  parameter int unsigned CNT_WIDTH   = 4,
  parameter int unsigned STATE_WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ena,
  input  logic                           cfg_we,
  input  logic [SYM_WIDTH-1:0]           cfg_sym,
  input  logic [CNT_WIDTH-1:0]           cfg_count,
  input  logic                           cfg_commit,
  output logic                           tbl_rdy,
  output logic                           err,
  input  logic [SYM_WIDTH-1:0]           sym_in,
  input  logic                           sym_vld,
  output logic                           sym_rdy,
  output logic [CNT_WIDTH-1:0]           s_count,
  output logic [SYM_WIDTH+CNT_WIDTH-1:0] s_cumulative,
  output logic [STATE_WIDTH-1:0]         total_count,
  output logic                           out_vld,
  input  logic                           out_rdy
);

  localparam int unsigned NUM_SYM   = 1 << SYM_WIDTH;
  localparam int unsigned ACC_WIDTH = SYM_WIDTH + CNT_WIDTH;
  localparam logic [SYM_WIDTH-1:0] IDX_LAST = SYM_WIDTH'(NUM_SYM - 1);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUILD = 2'd1,
    READY = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q [NUM_SYM];
  logic [ACC_WIDTH-1:0]   cum_q [NUM_SYM];
  logic [SYM_WIDTH-1:0]   idx_q;
  logic [ACC_WIDTH-1:0]   acc_q;
  logic [ACC_WIDTH-1:0]   total_q;
  logic [ACC_WIDTH-1:0]   build_sum;
  logic                   wr_en;
  logic                   commit_ok;
  logic                   build_step;
  logic                   zero_total;
  logic                   sym_fire;
  logic                   out_fire;
  logic                   sym_zero;

  // Running prefix sum including the entry currently being visited.
  assign build_sum  = acc_q + ACC_WIDTH'(cnt_q[idx_q]);
  assign build_step = (state_q == BUILD);

  assign tbl_rdy  = (state_q == READY);
  assign sym_rdy  = tbl_rdy & (~out_vld | out_rdy);
  // Transfers only happen on enabled cycles.
  assign sym_fire = ena & sym_vld & sym_rdy;
  assign out_fire = ena & out_vld & out_rdy;

`ifdef ANS_ZERO_SYM_CHECK_EN
  assign sym_zero = (cnt_q[sym_in] == '0);
`else
  assign sym_zero = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else if (ena) begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    wr_en      = 1'b0;
    commit_ok  = 1'b0;
    zero_total = 1'b0;
    case (state_q)
      EMPTY: begin
        wr_en = cfg_we;
        if (cfg_commit) begin
          state_d   = BUILD;
          commit_ok = 1'b1;
        end
      end
      BUILD: begin
        if (idx_q == IDX_LAST) begin
          if (build_sum == '0) begin
            state_d    = EMPTY;
            zero_total = 1'b1;
          end else begin
            state_d = READY;
          end
        end
      end
      READY: begin
        // A write invalidates the cumulative table, so it wins over commit.
        if (cfg_we) begin
          wr_en   = 1'b1;
          state_d = EMPTY;
        end else if (cfg_commit) begin
          state_d   = BUILD;
          commit_ok = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Frequency table, prefix-sum build and cumulative table.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '{default: '0};
      cum_q   <= '{default: '0};
      idx_q   <= '0;
      acc_q   <= '0;
      total_q <= '0;
    end else if (ena) begin
      if (wr_en) begin
        cnt_q[cfg_sym] <= cfg_count;
      end
      if (commit_ok) begin
        idx_q <= '0;
        acc_q <= '0;
      end else if (build_step) begin
        cum_q[idx_q] <= acc_q;
        acc_q        <= build_sum;
        idx_q        <= idx_q + SYM_WIDTH'(1);
        if (idx_q == IDX_LAST) begin
          total_q <= build_sum;
        end
      end
    end
  end

  // Sticky error; a new error in the same cycle as a commit takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (ena) begin
      if (zero_total || (sym_fire && sym_zero)) begin
        err <= 1'b1;
      end else if (commit_ok) begin
        err <= 1'b0;
      end
    end
  end

  // Output tuple register; a pending tuple is held until consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld      <= 1'b0;
      s_count      <= '0;
      s_cumulative <= '0;
      total_count  <= '0;
    end else if (ena) begin
      if (sym_fire && !sym_zero) begin
        out_vld      <= 1'b1;
        s_count      <= cnt_q[sym_in];
        s_cumulative <= cum_q[sym_in];
        total_count  <= STATE_WIDTH'(total_q);
      end else if (out_fire) begin
        out_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ans_freq_table.sv
// Testbench for ans_freq_table (default widths 4/4/8).
module tb_ans_freq_table;

  typedef struct {
    int c;
    int cum;
    int tot;
  } tuple_t;

  logic       clk;
  logic       rst;
  logic       ena;
  logic       cfg_we;
  logic [3:0] cfg_sym;
  logic [3:0] cfg_count;
  logic       cfg_commit;
  logic       tbl_rdy;
  logic       err;
  logic [3:0] sym_in;
  logic       sym_vld;
  logic       sym_rdy;
  logic [3:0] s_count;
  logic [7:0] s_cumulative;
  logic [7:0] total_count;
  logic       out_vld;
  logic       out_rdy;

  int     n_checks;
  int     n_bad;
  int     m_cnt [16];
  bit     m_err;
  int     pend [$];
  tuple_t exp_q [$];

  ans_freq_table dut (
    .clk          (clk),
    .rst          (rst),
    .ena          (ena),
    .cfg_we       (cfg_we),
    .cfg_sym      (cfg_sym),
    .cfg_count    (cfg_count),
    .cfg_commit   (cfg_commit),
    .tbl_rdy      (tbl_rdy),
    .err          (err),
    .sym_in       (sym_in),
    .sym_vld      (sym_vld),
    .sym_rdy      (sym_rdy),
    .s_count      (s_count),
    .s_cumulative (s_cumulative),
    .total_count  (total_count),
    .out_vld      (out_vld),
    .out_rdy      (out_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: cumulative = sum of counts of all lower symbols.
  function automatic int m_cum(input int s);
    int a;
    a = 0;
    for (int j = 0; j < s; j++) a += m_cnt[j];
    return a;
  endfunction

  function automatic int m_total();
    return m_cum(16);
  endfunction

  function automatic tuple_t m_tuple(input int s);
    tuple_t t;
    t.c   = m_cnt[s];
    t.cum = m_cum(s);
    t.tot = m_total();
    return t;
  endfunction

  function automatic void set_spec_table();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_cnt[0] = 3;
    m_cnt[1] = 5;
    m_cnt[2] = 8;
  endfunction

  task automatic program_table();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cfg_we    = 1'b1;
      cfg_sym   = 4'(i);
      cfg_count = 4'(m_cnt[i]);
    end
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Commit at E0; the table must come up exactly after edge E16.
  task automatic commit_build(input bit exp_ok);
    bit early;
    early = 1'b0;
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    m_err = 1'b0;
    n_checks++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL commit_err_clear: err=%b expected 0", err);
    end
    if (tbl_rdy !== 1'b0) early = 1'b1;
    for (int k = 2; k <= 16; k++) begin
      @(negedge clk);
      if (tbl_rdy !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_bad++;
      $display("FAIL build_early: tbl_rdy went high before 16 build cycles");
    end
    @(negedge clk);
    if (!exp_ok) m_err = 1'b1;
    n_checks++;
    if (tbl_rdy !== exp_ok || err !== m_err) begin
      n_bad++;
      $display("FAIL build_done: tbl_rdy=%b err=%b expected tbl_rdy=%b err=%b",
               tbl_rdy, err, exp_ok, m_err);
    end
  endtask

  // Drives the symbols in pend through the DUT and checks every tuple in order.
  task automatic run_stream(input int hold, input bit rand_rdy, output int cycles);
    bit     done;
    bit     fire_out;
    bit     fire_in;
    int     s;
    tuple_t t;
    done   = 1'b0;
    cycles = -1;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      n_checks++;
      if (out_vld !== (exp_q.size() != 0)) begin
        n_bad++;
        $display("FAIL stream_out_vld: out_vld=%b expected %0d (cycle %0d)",
                 out_vld, exp_q.size() != 0, cyc);
      end
      if (out_vld === 1'b1 && exp_q.size() != 0) begin
        n_checks++;
        if (s_count !== 4'(exp_q[0].c) || s_cumulative !== 8'(exp_q[0].cum) ||
            total_count !== 8'(exp_q[0].tot)) begin
          n_bad++;
          $display("FAIL stream_payload: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                   s_count, s_cumulative, total_count,
                   exp_q[0].c, exp_q[0].cum, exp_q[0].tot);
        end
      end
      if (pend.size() == 0 && exp_q.size() == 0 && out_vld !== 1'b1) begin
        done   = 1'b1;
        cycles = cyc;
      end else begin
        if (cyc < hold) out_rdy = 1'b0;
        else if (rand_rdy) out_rdy = ($urandom_range(0, 3) != 0);
        else out_rdy = 1'b1;
        sym_vld = (pend.size() != 0);
        sym_in  = (pend.size() != 0) ? 4'(pend[0]) : 4'($urandom_range(0, 15));
        #1;
        n_checks++;
        if (sym_rdy !== (exp_q.size() == 0 || out_rdy)) begin
          n_bad++;
          $display("FAIL stream_sym_rdy: sym_rdy=%b expected %0d (cycle %0d)",
                   sym_rdy, exp_q.size() == 0 || out_rdy, cyc);
        end
        fire_out = (out_vld === 1'b1) && out_rdy;
        fire_in  = sym_vld && (sym_rdy === 1'b1);
        if (fire_out && exp_q.size() != 0) void'(exp_q.pop_front());
        if (fire_in) begin
          s = pend.pop_front();
          t = m_tuple(s);
`ifdef ANS_ZERO_SYM_CHECK_EN
          if (t.c == 0) m_err = 1'b1;
          else exp_q.push_back(t);
`else
          exp_q.push_back(t);
`endif
        end
      end
    end
    sym_vld = 1'b0;
    out_rdy = 1'b0;
    if (!done) begin
      n_checks++;
      n_bad++;
      $display("FAIL stream_timeout: %0d symbols and %0d tuples outstanding",
               pend.size(), exp_q.size());
      pend.delete();
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    ena        = 1'b1;
    cfg_we     = 1'b0;
    cfg_sym    = '0;
    cfg_count  = '0;
    cfg_commit = 1'b0;
    sym_in     = 4'd1;
    sym_vld    = 1'b1;
    out_rdy    = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (tbl_rdy !== 1'b0 || err !== 1'b0 || sym_rdy !== 1'b0 || out_vld !== 1'b0 ||
        s_count !== 4'd0 || s_cumulative !== 8'd0 || total_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: tbl_rdy=%b err=%b sym_rdy=%b out_vld=%b tuple=(%0d,%0d,%0d) expected all 0",
               tbl_rdy, err, sym_rdy, out_vld, s_count, s_cumulative, total_count);
    end
    rst     = 1'b0;
    sym_vld = 1'b0;
  endtask

  task automatic test_build();
    int ls [2]   = '{2, 0};
    int lc [2]   = '{8, 3};
    int lcum [2] = '{8, 0};
    set_spec_table();
    program_table();
    commit_build(1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sym_vld = 1'b1;
      sym_in  = 4'(ls[i]);
      out_rdy = 1'b0;
      @(negedge clk);
      sym_vld = 1'b0;
      n_checks++;
      if (out_vld !== 1'b1 || s_count !== 4'(lc[i]) || s_cumulative !== 8'(lcum[i]) ||
          total_count !== 8'd16) begin
        n_bad++;
        $display("FAIL lookup_sym%0d: out_vld=%b got (%0d,%0d,%0d) expected (%0d,%0d,16)",
                 ls[i], out_vld, s_count, s_cumulative, total_count, lc[i], lcum[i]);
      end
      out_rdy = 1'b1;
      @(negedge clk);
      out_rdy = 1'b0;
      n_checks++;
      if (out_vld !== 1'b0) begin
        n_bad++;
        $display("FAIL lookup_consume: out_vld=%b expected 0", out_vld);
      end
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    pend.push_back(1);
    pend.push_back(2);
    pend.push_back(0);
    run_stream(3, 1'b0, cyc);
    // 1 accept cycle + 2 held + 3 deliveries at one per cycle.
    n_checks++;
    if (cyc != 6) begin
      n_bad++;
      $display("FAIL backpressure_throughput: drained at cycle %0d expected 6", cyc);
    end
  endtask

  task automatic test_zero_symbol();
    int cyc;
    pend.push_back(5);
    run_stream(0, 1'b0, cyc);
`ifdef ANS_ZERO_SYM_CHECK_EN
    n_checks++;
    if (err !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_sym_err: err=%b expected 1", err);
    end
    commit_build(1'b1);
`else
    n_checks++;
    if (err !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_sym_err: err=%b expected 0", err);
    end
`endif
  endtask

  task automatic test_ena();
    bit early;
    @(negedge clk);
    sym_vld = 1'b1;
    sym_in  = 4'd1;
    out_rdy = 1'b0;
    @(negedge clk);
    sym_vld = 1'b0;
    ena     = 1'b0;
    out_rdy = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (out_vld !== 1'b1 || s_count !== 4'd5 || s_cumulative !== 8'd3) begin
      n_bad++;
      $display("FAIL ena_hold: out_vld=%b tuple=(%0d,%0d) expected 1 (5,3)",
               out_vld, s_count, s_cumulative);
    end
    ena = 1'b1;
    @(negedge clk);
    out_rdy = 1'b0;
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL ena_consume: out_vld=%b expected 0", out_vld);
    end
    // Five disabled edges during a build stretch it by five cycles.
    early = 1'b0;
    @(negedge clk);
    cfg_commit = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(negedge clk);
      if (k == 1) cfg_commit = 1'b0;
      if (k == 3) ena = 1'b0;
      if (k == 8) ena = 1'b1;
      if (tbl_rdy !== 1'b0) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_bad++;
      $display("FAIL ena_build_early: tbl_rdy high while build stalled");
    end
    @(negedge clk);
    n_checks++;
    if (tbl_rdy !== 1'b1) begin
      n_bad++;
      $display("FAIL ena_build_done: tbl_rdy=%b expected 1", tbl_rdy);
    end
  endtask

  task automatic test_reconfig();
    tuple_t t;
    t = m_tuple(1);
    @(negedge clk);
    sym_vld = 1'b1;
    sym_in  = 4'd1;
    out_rdy = 1'b0;
    @(negedge clk);
    sym_vld   = 1'b0;
    cfg_we    = 1'b1;
    cfg_sym   = 4'd2;
    cfg_count = 4'd7;
    @(negedge clk);
    cfg_we   = 1'b0;
    m_cnt[2] = 7;
    n_checks++;
    if (tbl_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL reconfig_tbl_rdy: tbl_rdy=%b expected 0", tbl_rdy);
    end
    n_checks++;
    if (out_vld !== 1'b1 || s_count !== 4'(t.c) || s_cumulative !== 8'(t.cum) ||
        total_count !== 8'(t.tot)) begin
      n_bad++;
      $display("FAIL reconfig_pending: out_vld=%b got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
               out_vld, s_count, s_cumulative, total_count, t.c, t.cum, t.tot);
    end
    sym_vld = 1'b1;
    sym_in  = 4'd0;
    out_rdy = 1'b1;
    #1;
    n_checks++;
    if (sym_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL reconfig_sym_rdy: sym_rdy=%b expected 0", sym_rdy);
    end
    @(negedge clk);
    sym_vld = 1'b0;
    out_rdy = 1'b0;
    n_checks++;
    if (out_vld !== 1'b0) begin
      n_bad++;
      $display("FAIL reconfig_deliver: out_vld=%b expected 0", out_vld);
    end
  endtask

  task automatic test_zero_total();
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    program_table();
    commit_build(1'b0);
    sym_vld = 1'b1;
    sym_in  = 4'd3;
    out_rdy = 1'b1;
    #1;
    n_checks++;
    if (sym_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL zero_total_sym_rdy: sym_rdy=%b expected 0", sym_rdy);
    end
    @(negedge clk);
    sym_vld = 1'b0;
    out_rdy = 1'b0;
  endtask

  task automatic test_reset_mid_build();
    set_spec_table();
    program_table();
    @(negedge clk);
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) m_cnt[i] = 0;
    m_err = 1'b0;
    n_checks++;
    if (tbl_rdy !== 1'b0 || out_vld !== 1'b0 || err !== 1'b0 || s_count !== 4'd0 ||
        s_cumulative !== 8'd0 || total_count !== 8'd0) begin
      n_bad++;
      $display("FAIL reset_mid_build: tbl_rdy=%b out_vld=%b err=%b tuple=(%0d,%0d,%0d) expected all 0",
               tbl_rdy, out_vld, err, s_count, s_cumulative, total_count);
    end
    repeat (20) @(negedge clk);
    n_checks++;
    if (tbl_rdy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_abort: tbl_rdy=%b expected 0 after aborted build", tbl_rdy);
    end
  endtask

  task automatic test_random();
    int cyc;
    int sum;
    for (int r = 0; r < 3; r++) begin
      sum = 0;
      for (int i = 0; i < 16; i++) begin
        m_cnt[i] = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 15));
        sum += m_cnt[i];
      end
      if (sum == 0) m_cnt[0] = 1;
      program_table();
      commit_build(1'b1);
      for (int n = 0; n < 40; n++) pend.push_back(int'($urandom_range(0, 15)));
      run_stream(0, 1'b1, cyc);
      n_checks++;
      if (err !== m_err) begin
        n_bad++;
        $display("FAIL random_err: err=%b expected %b (round %0d)", err, m_err, r);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_bad    = 0;
    test_reset();
    test_build();
    test_backpressure();
    test_zero_symbol();
    test_ena();
    test_reconfig();
    test_zero_total();
    test_reset_mid_build();
    test_random();
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/ans_freq_table.md
# ans_freq_table

Symbol-model stage directly upstream of `ans_encoder`. It holds a programmable per-symbol frequency table and builds the cumulative-frequency table with a sequential prefix sum. It then converts a stream of raw symbols into the `(s_count, s_cumulative, total_count)` tuples the encoder consumes, using a valid/ready handshake on both sides.

## Interface
- `SYM_WIDTH`, default 4: symbol width; the table has `2^SYM_WIDTH` entries.
- `CNT_WIDTH`, default 4: width of each frequency count.
- `STATE_WIDTH`, default 8: width of `total_count`, matching the encoder state.
- `clk`  in  1: clock. All logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ena`  in  1: clock enable. When low, all state holds.
- `cfg_we`  in  1: write one frequency entry.
- `cfg_sym`  in  SYM_WIDTH: entry index.
- `cfg_count`  in  CNT_WIDTH: frequency value.
- `cfg_commit`  in  1: start the cumulative-table build.
- `tbl_rdy`  out  1: table built; lookups are accepted.
- `err`  out  1: sticky error flag.
- `sym_in`  in  SYM_WIDTH: symbol to encode.
- `sym_vld`  in  1: `sym_in` is valid.
- `sym_rdy`  out  1: stage accepts `sym_in`.
- `s_count`  out  CNT_WIDTH: frequency of the symbol.
- `s_cumulative`  out  SYM_WIDTH+CNT_WIDTH: sum of the frequencies of all lower symbols.
- `total_count`  out  STATE_WIDTH: sum of all frequencies, zero-extended.
- `out_vld`  out  1: tuple is valid; connects to encoder `in_vld`.
- `out_rdy`  in  1: consumer ready; connects to encoder `in_rdy`.

## Operation
- FSM states: EMPTY, BUILD, READY. `tbl_rdy` = (state == READY).
- **EMPTY**
  - `cfg_we` writes `cnt[cfg_sym] <= cfg_count`.
  - `cfg_commit` moves to BUILD with `idx <= 0` and `acc <= 0`.
  - If `cfg_we` and `cfg_commit` are both high, the write lands first and the build sees the new value.
- **BUILD**: one entry per cycle.
  - `cum[idx] <= acc`, `acc <= acc + cnt[idx]`, `idx <= idx + 1`.
  - When `idx == 2^SYM_WIDTH - 1`: latch `total <= acc + cnt[idx]`.
  - If that total is 0, go to EMPTY and set `err`. Otherwise go to READY.
  - `cfg_we` and `cfg_commit` are ignored in BUILD.
- **READY**
  - `cfg_we` performs the write and drops to EMPTY.
  - `cfg_commit` alone restarts BUILD.
  - A tuple already in the output register is held until it is consumed; it is never dropped.
- **Lookup**: `sym_rdy = tbl_rdy & (!out_vld | out_rdy)`. On `sym_vld & sym_rdy`, the output register loads `cnt[sym_in]`, `cum[sym_in]`, `total`, and `out_vld <= 1`.
- **Output**: `out_vld` clears on `out_vld & out_rdy` unless a new symbol is accepted in the same cycle, which gives full throughput.
- **Arithmetic**: the accumulator is SYM_WIDTH+CNT_WIDTH bits and cannot overflow (max `2^SYM_WIDTH * (2^CNT_WIDTH - 1)`).
- **err**: cleared only by `rst` or by an accepted `cfg_commit`.
- **Reset**: all `cnt`/`cum` = 0, `total` = 0, state EMPTY.
  - Outputs: `tbl_rdy` = 0, `err` = 0, `sym_rdy` = 0, `out_vld` = 0, `s_count` = 0, `s_cumulative` = 0, `total_count` = 0.
  - Reset mid-build aborts the build.

## Timing
- `cfg_commit` sampled at edge E0 → BUILD covers edges E1..E(2^SYM_WIDTH) → `tbl_rdy` is high after edge E(2^SYM_WIDTH). This is 16 cycles at the default width.
- Lookup latency: 1 cycle from acceptance to `out_vld`. One symbol per cycle sustained.
- Payload stability: while `out_vld & !out_rdy`, the payload and `out_vld` stay stable and `sym_rdy` = 0.
- `ena` low: every register holds. The handshakes are also qualified by `ena`, so no transfer occurs in that cycle.

## Configuration
- Macro: `ANS_ZERO_SYM_CHECK_EN`.
- **Defined**: an accepted symbol with `cnt == 0` is consumed but produces no tuple (`out_vld` is not set) and sets `err`.
- **Undefined**: the tuple passes through with `s_count = 0`, and `err` is driven only by the zero-total build.

## Test plan
- **Reset/empty**: assert `rst` for 2 cycles → all outputs 0, `sym_rdy` = 0 while `sym_vld` = 1.
- **Build**: program counts sym0 = 3, sym1 = 5, sym2 = 8, others 0, then commit → `tbl_rdy` rises 16 cycles later.
  - Lookup sym2 → `s_count` = 8, `s_cumulative` = 8, `total_count` = 16.
  - Lookup sym0 → `s_cumulative` = 0.
- **Backpressure**: stream sym1, sym2, sym0 with `out_rdy` low for 3 cycles → payload held at sym1 (5, 3, 16) and `sym_rdy` = 0.
  - When `out_rdy` is released, the tuples arrive in order, one per cycle.
- **Zero symbol**: with `ANS_ZERO_SYM_CHECK_EN` defined, send sym5 (count 0) → no `out_vld`, `err` = 1.
  - A later commit clears `err`.
  - Without the macro, the tuple is (0, 16, 16) and `err` = 0.
- **Zero total**: commit with all counts 0 → state returns to EMPTY after 16 cycles, `err` = 1, `tbl_rdy` = 0.
- **Reconfigure mid-stream**: in READY, hold a pending tuple and pulse `cfg_we` → `tbl_rdy` = 0 immediately and the pending tuple is still delivered on `out_rdy`.
  - Pulsing `rst` during BUILD → state EMPTY the next cycle.
